phys_free_list: RTL and testbench
=================================

# phys_free_list

Physical-register free list for the rename stage. It supplies up to four new destination tags per cycle, and those tags are written into the 8-read/4-write rename map table on the same dispatch group. Freed tags from retirement are pushed back four per cycle. The block keeps a committed head so that branch or exception recovery returns every speculatively allocated tag in one cycle.

## Interface
- PHY_REGS, 96, number of physical registers
- LOG_REGS, 32, number of architectural registers; DEPTH = PHY_REGS-LOG_REGS (64)
- TAG, 7, physical tag width (clog2 PHY_REGS)
- CNT, 7, counter width (clog2 DEPTH+1)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_i  in  4  per-lane allocation request mask (any pattern)
- fire_i  in  1  rename group advances this cycle
- tag0_o..tag3_o  out  TAG  allocated tag per lane
- stall_o  out  1  insufficient free tags for req_i
- free_val_i  in  4  per-lane push valid (retire)
- free_tag0_i..free_tag3_i  in  TAG  tags being freed
- commit_i  in  4  per-lane mask of retiring instructions with a destination
- recover_i  in  1  flush; discard speculative allocations
- count_o  out  CNT  free entries
- error_o  out  1  sticky consistency error (only with FREE_LIST_CHECK_EN)

## Operation
- Storage is a circular buffer of DEPTH entries.
- State:
  - head: allocation pointer
  - tail: push pointer
  - cmt_head: committed head
  - count: free entries
  - spec_cnt: allocated but uncommitted tags
- Reset:
  - entry[i] = LOG_REGS+i
  - head = tail = cmt_head = 0
  - count = DEPTH, spec_cnt = 0
- Reset values of outputs: count_o = 64, stall_o = 0 for any req_i (count ≥ 4), error_o = 0.
- npop = popcount(req_i). stall_o = (count < npop).
- Allocation fires when fire_i & ~stall_o & ~recover_i.
- Output tags:
  - Lane k reads entry[(head + popcount(req_i[k-1:0])) mod DEPTH].
  - Unrequested lanes output 0.
  - Tags are valid whether or not the allocation fires.
- Push compaction: valid free lanes are packed in lane order starting at tail. tail += npush.
- Commit: cmt_head += ncommit.
- Normal cycle:
  - head += npop_eff
  - count += npush - npop_eff
  - spec_cnt += npop_eff - ncommit
- Recover cycle:
  - The push and commit for the cycle are still applied.
  - head = cmt_head + ncommit.
  - count += npush + spec_cnt - ncommit.
  - spec_cnt = 0.
  - Allocation is suppressed.
- Pointer arithmetic is modulo DEPTH. head == tail means empty or full; count disambiguates.
- Full buffer: push with count+npush-npop_eff > DEPTH is illegal; the upstream guarantees it never happens.

## Timing
- Tag outputs and stall_o are combinational from current state and req_i; there is zero-cycle allocation latency.
- All pointer and counter updates take effect at the next posedge.
- Tags pushed in cycle N are allocatable from cycle N+1. stall_o never counts same-cycle pushes, so there is no bypass.
- Reset asserted mid-operation discards everything and reloads the reset image at the next edge.

## Configuration
- FREE_LIST_CHECK_EN defined:
  - error_o is set (sticky until reset) when ncommit > spec_cnt + npop_eff.
  - It is also set on push overflow (count would exceed DEPTH).
- Not defined: error_o is tied to 0 and the check logic is absent.

## Structure
- Shared package holds:
  - PHY_REGS, LOG_REGS, TAG
  - the free-list DEPTH constant
  - a free_tag_t typedef
- Sub-module free_list_ram holds the storage:
  - DEPTH x TAG
  - 4 combinational reads, 4 synchronous writes
  - reset loads the LOG_REGS+i image
- Pointer/count logic and lane compaction live in phys_free_list.

## Test plan
- Reset, req_i=1111, fire_i=1: tags 32,33,34,35. Next cycle count_o=60.
- From reset, req_i=1010, fire: tag1=32, tag3=33, tag0=tag2=0. Next cycle count_o=62. A following req_i=1111 gives 34..37.
- Exhaustion and wrap:
  - 16 full allocations bring count_o to 0; stall_o=1 for req_i=0001 and no pointer moves.
  - Push free_val_i=0101 with tags 40,41 into slots 0,1.
  - Next cycle req_i=0011 gives 40,41.
- Recovery:
  - From reset, allocate 8 and commit_i=0111.
  - Then recover_i=1: count_o=61, and the next req_i=0001 returns 35.
- Balanced traffic: with count=4, pop 4, push 4 and commit 4 in the same cycle: count_o stays 4, stall_o=0, pushed tags are returned 1 cycle later.
- With FREE_LIST_CHECK_EN: commit_i=0001 straight after reset sets error_o=1, which holds until reset. Without the macro, error_o stays 0.

Source files
------------

// File: rtl/phys_free_list_pkg.sv
// Shared definitions for the rename-stage physical-register free list.
//   PHY_REGS / LOG_REGS / TAG : register file geometry and tag width
//   DEPTH                     : free-list capacity (PHY_REGS - LOG_REGS)
//   free_tag_t                : one physical tag
//   ptr_add                   : circular-buffer pointer increment (mod DEPTH)
package phys_free_list_pkg;

    localparam int PHY_REGS = 96;
    localparam int LOG_REGS = 32;
    localparam int TAG      = 7;
    localparam int DEPTH    = PHY_REGS - LOG_REGS;
    localparam int CNT      = $clog2(DEPTH + 1);
    localparam int PTR      = $clog2(DEPTH);

    typedef logic [TAG-1:0] free_tag_t;
    typedef logic [PTR-1:0] ptr_t;
    typedef logic [CNT-1:0] cnt_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Increments never exceed 4, so one conditional subtract keeps the
    // result inside [0, DEPTH) even when DEPTH is not a power of two.
    function automatic ptr_t ptr_add(input ptr_t p, input logic [2:0] inc);
        logic [PTR:0] s;
        s = {1'b0, p} + (PTR+1)'(inc);
        if (s >= (PTR+1)'(DEPTH))
            s = s - (PTR+1)'(DEPTH);
        return s[PTR-1:0];
    endfunction

endpackage

// File: rtl/phys_free_list_ram.sv
// Free-list storage: DEPTH entries of TAG bits.
//   clk, reset : clock and synchronous active-high reset (reloads LOG_REGS+i)
//   raddr_i    : four combinational read addresses -> rdata_o
//   we_i, waddr_i, wdata_i : four synchronous write ports
// Write addresses within one cycle are always distinct (lane compaction).
module free_list_ram
    import phys_free_list_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  ptr_t      [3:0]   raddr_i,
    output free_tag_t [3:0]   rdata_o,
    input  logic      [3:0]   we_i,
    input  ptr_t      [3:0]   waddr_i,
    input  free_tag_t [3:0]   wdata_i
);

    free_tag_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= free_tag_t'(LOG_REGS + i);
        end else begin
            for (int k = 0; k < 4; k++)
                if (we_i[k])
                    mem_q[waddr_i[k]] <= wdata_i[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            rdata_o[k] = mem_q[raddr_i[k]];
    end

endmodule

// File: rtl/phys_free_list.sv
// Physical-register free list: allocates up to four tags per cycle for the
// rename group, accepts four freed tags per cycle from retirement, and keeps
// a committed head so recovery returns all speculative tags in one cycle.
//   req_i/fire_i        : allocation lane mask / group advances
//   tag0_o..tag3_o      : allocated tag per lane (0 on unrequested lanes)
//   stall_o             : fewer free entries than requested lanes
//   free_val_i/free_tagN_i : retirement pushes, compacted in lane order
//   commit_i            : retiring instructions that own an allocated tag
//   recover_i           : flush speculative allocations
//   count_o             : free entries
//   error_o             : sticky consistency error
// Optional feature: define FREE_LIST_CHECK_EN to enable error_o checking;
// otherwise error_o is tied low.
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     req_i,
    input  logic           fire_i,
    output logic [TAG-1:0] tag0_o,
    output logic [TAG-1:0] tag1_o,
    output logic [TAG-1:0] tag2_o,
    output logic [TAG-1:0] tag3_o,
    output logic           stall_o,
    input  logic [3:0]     free_val_i,
    input  logic [TAG-1:0] free_tag0_i,
    input  logic [TAG-1:0] free_tag1_i,
    input  logic [TAG-1:0] free_tag2_i,
    input  logic [TAG-1:0] free_tag3_i,
    input  logic [3:0]     commit_i,
    input  logic           recover_i,
    output logic [CNT-1:0] count_o,
    output logic           error_o
);

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t cmt_q,  cmt_d;
    cnt_t count_q, count_d;
    cnt_t spec_q,  spec_d;

    logic [2:0] npop, npush, ncommit, npop_eff;
    logic       alloc;

    ptr_t      [3:0] raddr;
    free_tag_t [3:0] rdata;
    ptr_t      [3:0] waddr;
    free_tag_t [3:0] wdata;

    free_list_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .raddr_i (raddr),
        .rdata_o (rdata),
        .we_i    (free_val_i),
        .waddr_i (waddr),
        .wdata_i (wdata)
    );

    assign wdata = {free_tag3_i, free_tag2_i, free_tag1_i, free_tag0_i};

    always_comb begin
        logic [2:0] rd_run;
        logic [2:0] wr_run;

        npop    = popcnt4(req_i);
        npush   = popcnt4(free_val_i);
        ncommit = popcnt4(commit_i);

        // Only current state is compared: same-cycle pushes are never bypassed.
        stall_o  = count_q < cnt_t'(npop);
        alloc    = fire_i & ~stall_o & ~recover_i;
        npop_eff = alloc ? npop : 3'd0;

        // Lane k reads head + (number of requesting lanes below k); pushes
        // pack the same way starting at tail.
        rd_run = 3'd0;
        wr_run = 3'd0;
        for (int k = 0; k < 4; k++) begin
            raddr[k] = ptr_add(head_q, rd_run);
            waddr[k] = ptr_add(tail_q, wr_run);
            rd_run   = rd_run + 3'(req_i[k]);
            wr_run   = wr_run + 3'(free_val_i[k]);
        end

        tag0_o = req_i[0] ? rdata[0] : '0;
        tag1_o = req_i[1] ? rdata[1] : '0;
        tag2_o = req_i[2] ? rdata[2] : '0;
        tag3_o = req_i[3] ? rdata[3] : '0;

        cmt_d  = ptr_add(cmt_q, ncommit);
        tail_d = ptr_add(tail_q, npush);
        if (recover_i) begin
            // Everything past the new committed head becomes free again.
            head_d  = cmt_d;
            count_d = count_q + cnt_t'(npush) + spec_q - cnt_t'(ncommit);
            spec_d  = '0;
        end else begin
            head_d  = ptr_add(head_q, npop_eff);
            count_d = count_q + cnt_t'(npush) - cnt_t'(npop_eff);
            spec_d  = spec_q + cnt_t'(npop_eff) - cnt_t'(ncommit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            cmt_q   <= '0;
            count_q <= cnt_t'(DEPTH);
            spec_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cmt_q   <= cmt_d;
            count_q <= count_d;
            spec_q  <= spec_d;
        end
    end

    assign count_o = count_q;

`ifdef FREE_LIST_CHECK_EN
    localparam int W = CNT + 2;

    logic         err_q, err_d;
    logic [W-1:0] avail_w, next_cnt_w;

    // Widened sums so neither condition can be hidden by wrap-around.
    // An over-commit can underflow next_cnt_w, but that case is already
    // flagged by the commit check.
    always_comb begin
        avail_w = W'(spec_q) + W'(npop_eff);
        if (recover_i)
            next_cnt_w = W'(count_q) + W'(npush) + W'(spec_q) - W'(ncommit);
        else
            next_cnt_w = W'(count_q) + W'(npush) - W'(npop_eff);
        err_d = err_q | (W'(ncommit) > avail_w) | (next_cnt_w > W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic       fire = 1'b0;
    logic [3:0] fval = '0;
    logic [6:0] ft0 = '0, ft1 = '0, ft2 = '0, ft3 = '0;
    logic [3:0] cmt = '0;
    logic       rec = 1'b0;
    logic [6:0] tag0, tag1, tag2, tag3;
    logic       stall;
    logic [6:0] cnt;
    logic       err;

`ifdef FREE_LIST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    phys_free_list dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .fire_i      (fire),
        .tag0_o      (tag0),
        .tag1_o      (tag1),
        .tag2_o      (tag2),
        .tag3_o      (tag3),
        .stall_o     (stall),
        .free_val_i  (fval),
        .free_tag0_i (ft0),
        .free_tag1_i (ft1),
        .free_tag2_i (ft2),
        .free_tag3_i (ft3),
        .commit_i    (cmt),
        .recover_i   (rec),
        .count_o     (cnt),
        .error_o     (err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: fl holds every tag from the committed head to the
    // push end, in order. The first 'spec' are allocated-but-uncommitted;
    // the rest are free.
    int fl[$];
    int spec;
    bit err_m;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic int popc(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic model_reset();
        fl.delete();
        for (int i = 0; i < 64; i++) fl.push_back(32 + i);
        spec  = 0;
        err_m = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req = '0; fire = 1'b0; fval = '0; cmt = '0; rec = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drv(input logic [3:0] r, input logic f, input logic [3:0] fv,
                       input int a, input int b, input int c, input int d,
                       input logic [3:0] cm, input logic rc);
        @(posedge clk); #1;
        req = r; fire = f; fval = fv; cmt = cm; rec = rc;
        ft0 = a[6:0]; ft1 = b[6:0]; ft2 = c[6:0]; ft3 = d[6:0];
    endtask

    // Checks outputs mid-cycle against the model, then advances the model
    // by the effect of the currently driven inputs.
    task automatic tick();
        int cntm, npop, npe, nc, np, pre, idx;
        logic [6:0] tg [4];
        logic [6:0] fts [4];
        @(negedge clk);
        cntm = fl.size() - spec;
        npop = popc(req);
        chk("count", cnt, cntm);
        chk("stall", stall, cntm < npop);
        chk("error", err, err_m);
        tg  = '{tag0, tag1, tag2, tag3};
        fts = '{ft0, ft1, ft2, ft3};
        pre = 0;
        for (int k = 0; k < 4; k++) begin
            if (req[k]) begin
                idx = spec + pre;
                if (idx < fl.size()) chk($sformatf("tag%0d", k), tg[k], fl[idx]);
                pre++;
            end else begin
                chk($sformatf("tag%0d_idle", k), tg[k], 0);
            end
        end
        npe = (fire && !(cntm < npop) && !rec) ? npop : 0;
        nc  = popc(cmt);
        np  = popc(fval);
        if (CHK) begin
            if (nc > spec + npe) err_m = 1'b1;
            if (rec ? (cntm + np + spec - nc > 64) : (cntm + np - npe > 64)) err_m = 1'b1;
        end
        spec += npe;
        for (int k = 0; k < 4; k++) if (fval[k]) fl.push_back(int'(fts[k]));
        for (int k = 0; k < nc; k++) void'(fl.pop_front());
        spec -= nc;
        if (rec) spec = 0;
    endtask

    initial begin
        logic [3:0] r, fv, cm;
        logic f, rc;
        int lim;

        do_reset();

        // Full group from reset, then count reflects it.
        drv(4'b1111, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t1_tag0", tag0, 32); chk("t1_tag1", tag1, 33);
        chk("t1_tag2", tag2, 34); chk("t1_tag3", tag3, 35);
        drv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t1_count", cnt, 60);

        // Sparse request mask.
        do_reset();
        drv(4'b1010, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t2_tag0", tag0, 0);  chk("t2_tag1", tag1, 32);
        chk("t2_tag2", tag2, 0);  chk("t2_tag3", tag3, 33);
        drv(4'b1111, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t2_count", cnt, 62);
        chk("t2_tag0b", tag0, 34); chk("t2_tag3b", tag3, 37);

        // Exhaustion, no same-cycle bypass, wrap.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drv(4'b1111, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        end
        drv(4'b0001, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t3_count0", cnt, 0); chk("t3_stall", stall, 1);
        drv(4'b0001, 1, 4'b0101, 40, 0, 41, 0, 0, 0); tick();
        chk("t3_nobypass", stall, 1);
        drv(4'b0011, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t3_stall_off", stall, 0);
        chk("t3_tag0", tag0, 40); chk("t3_tag1", tag1, 41);

        // Recovery to committed head.
        do_reset();
        drv(4'b1111, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(4'b1111, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0111, 0); tick();
        drv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(4'b0001, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t4_count", cnt, 61); chk("t4_tag0", tag0, 35);

        // Balanced traffic at count 4.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drv(4'b1111, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        end
        drv(4'b1111, 1, 4'b1111, 10, 11, 12, 13, 4'b1111, 0); tick();
        chk("t5_count", cnt, 4); chk("t5_stall", stall, 0);
        drv(4'b1111, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t5_count_next", cnt, 4);
        chk("t5_tag0", tag0, 10); chk("t5_tag3", tag3, 13);

        // Commit with nothing outstanding.
        do_reset();
        drv(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0001, 0);
        @(negedge clk); chk("t6_err_pre", err, 0);
        drv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("t6_err_set", err, CHK);
        drv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("t6_err_hold", err, CHK);
        do_reset();
        drv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("t6_err_clr", err, 0);

        // Randomized legal traffic against the model, with a mid-run reset.
        do_reset();
        for (int it = 0; it < 600; it++) begin
            r  = 4'($urandom_range(0, 15));
            f  = ($urandom_range(0, 7) != 0);
            rc = ($urandom_range(0, 19) == 0);
            cm = 4'($urandom_range(0, 15));
            while (popc(cm) > spec) cm = cm & (cm - 4'd1);
            lim = 64 - fl.size() + popc(cm);
            fv = 4'($urandom_range(0, 15));
            while (popc(fv) > lim) fv = fv & (fv - 4'd1);
            drv(r, f, fv, $urandom_range(0, 95), $urandom_range(0, 95),
                $urandom_range(0, 95), $urandom_range(0, 95), cm, rc);
            tick();
            if (it == 300) begin
                do_reset();
                drv(4'b1111, 1, 0, 0, 0, 0, 0, 0, 0); tick();
                chk("rst_mid_tag0", tag0, 32); chk("rst_mid_tag3", tag3, 35);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
